// File: rtl/pedal_error_gen_if.sv
// Sensor-side and controller-side signals of the pedal error generator.
// The producer (sensor front end / bench) uses master; the block uses slave.
interface pedal_error_gen_if;
    logic        curr_vld;
    logic [11:0] curr;
    logic        torque_vld;
    logic [11:0] torque;
    logic        cadence_raw;
    logic [2:0]  scale;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] error;

    modport master (
        output curr_vld, curr, torque_vld, torque, cadence_raw, scale,
        input  avg_curr, avg_torque, cadence, not_pedaling, error
    );

    modport slave (
        input  curr_vld, curr, torque_vld, torque, cadence_raw, scale,
        output avg_curr, avg_torque, cadence, not_pedaling, error
    );
endinterface

// File: rtl/pedal_error_gen.sv
// Conditions current, torque and cadence sensor data into the signed error
// and not_pedaling inputs of the assist PID controller.
module pedal_error_gen #(
    parameter bit          FAST_SIM   = 1'b0,
    parameter logic [11:0] TORQUE_MIN = 12'h380
) (
    input logic              clk,
    input logic              rst,
    pedal_error_gen_if.slave bus
);
    localparam int unsigned WIN_W = FAST_SIM ? 12 : 20;

    logic             sync1_q, sync2_q, rise_q;
    logic             edge_c;
    logic [4:0]       edges_q, edges_d;
    logic [WIN_W-1:0] win_q;
    logic [4:0]       cadence_q;
    logic             not_ped_q;
    logic [13:0]      ca_q, ca_d;
    logic [16:0]      ta_q, ta_d;
    logic [11:0]      avg_torque_c;
    logic [11:0]      d_c;
    logic [19:0]      prod_q, prod_d;
    logic [11:0]      target_q, target_d;
    logic [12:0]      error_q, error_d;

    assign edge_c = sync2_q & ~rise_q;

    // Saturating count that already includes an edge seen on this cycle,
    // so an edge on the terminal cycle lands in the closing window.
    always_comb begin
        edges_d = edges_q;
        if (edge_c && (edges_q != 5'd31)) begin
            edges_d = edges_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            rise_q    <= 1'b0;
            edges_q   <= '0;
            win_q     <= '0;
            cadence_q <= '0;
            not_ped_q <= 1'b1;
        end else begin
            sync1_q <= bus.cadence_raw;
            sync2_q <= sync1_q;
            rise_q  <= sync2_q;
            win_q   <= win_q + 1'b1;
            if (&win_q) begin
                cadence_q <= edges_d;
                not_ped_q <= (edges_d < 5'd2);
                edges_q   <= '0;
            end else begin
                edges_q <= edges_d;
            end
        end
    end

    assign ca_d = ca_q - {2'b00, ca_q[13:2]} + {2'b00, bus.curr};
    assign ta_d = ta_q - {5'b00000, ta_q[16:5]} + {5'b00000, bus.torque};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_q <= '0;
            ta_q <= '0;
        end else begin
            if (bus.curr_vld) begin
                ca_q <= ca_d;
            end
            if (not_ped_q) begin
                ta_q <= '0;
            end else if (bus.torque_vld) begin
                ta_q <= ta_d;
            end
        end
    end

    assign avg_torque_c = ta_q[16:5];

    always_comb begin
        d_c = '0;
        if (avg_torque_c > TORQUE_MIN) begin
            d_c = avg_torque_c - TORQUE_MIN;
        end
        prod_d = {8'd0, d_c} * {17'd0, bus.scale} * {15'd0, cadence_q};

        target_d = prod_q[16:5];
        if (|prod_q[19:17]) begin
            target_d = '1;
        end
        if (not_ped_q) begin
            target_d = '0;
        end

        error_d = {1'b0, target_q} - {1'b0, ca_q[13:2]};
        if (not_ped_q) begin
            error_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            target_q <= '0;
            error_q  <= '0;
        end else begin
            prod_q   <= prod_d;
            target_q <= target_d;
            error_q  <= error_d;
        end
    end

    assign bus.avg_curr     = ca_q[13:2];
    assign bus.avg_torque   = avg_torque_c;
    assign bus.cadence      = cadence_q;
    assign bus.not_pedaling = not_ped_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_pedal_error_gen.sv
// Scoreboard bench for pedal_error_gen with a 4096-cycle cadence window.
module tb_pedal_error_gen;
    localparam int K_CURR = 0, K_TORQ = 1, K_CAD = 2, K_NP = 3, K_ERR = 4;

    typedef struct {
        int          k;
        logic [12:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [16:0] m_ta = '0;

    pedal_error_gen_if bif ();

    pedal_error_gen #(.FAST_SIM(1'b1), .TORQUE_MIN(12'h380)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: compares every pending expectation against the live outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.k)
                K_CURR:  act = {1'b0, bif.avg_curr};
                K_TORQ:  act = {1'b0, bif.avg_torque};
                K_CAD:   act = {8'd0, bif.cadence};
                K_NP:    act = {12'd0, bif.not_pedaling};
                default: act = bif.error;
            endcase
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cyc %0d)", e.nm, act, e.v, cyc);
            end
        end
    end

    task automatic expect_v(input int k, input logic [12:0] v, input string nm);
        exp_t e;
        e.k = k; e.v = v; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bif.cadence_raw = 1'b1; tick(); tick();
        bif.cadence_raw = 1'b0; tick(); tick();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc != target && guard < 30000) begin
            tick();
            guard++;
        end
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: reached %0d required %0d", cyc, target);
        end
    endtask

    task automatic strobes(input int n, input logic [11:0] t, input logic [11:0] c);
        bif.torque = t; bif.curr = c;
        bif.torque_vld = 1'b1; bif.curr_vld = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            m_ta = m_ta - {5'd0, m_ta[16:5]} + {5'd0, t};
        end
        bif.torque_vld = 1'b0; bif.curr_vld = 1'b0;
    endtask

    function automatic logic [12:0] err_of(input logic [11:0] at, input int sc, input int cd,
                                           input logic [11:0] ac);
        int unsigned d, p;
        logic [11:0] t;
        d = (at > 12'h380) ? int'(at) - 'h380 : 0;
        p = d * sc * cd;
        t = (p >= 131072) ? 12'hFFF : 12'(p >> 5);
        return {1'b0, t} - {1'b0, ac};
    endfunction

    initial begin
        logic [12:0] e_new;
        bif.curr_vld = 1'b0; bif.curr = '0;
        bif.torque_vld = 1'b0; bif.torque = '0;
        bif.cadence_raw = 1'b0; bif.scale = 3'd0;

        repeat (5) tick();
        expect_v(K_CURR, 13'h0, "rst_avg_curr");
        expect_v(K_TORQ, 13'h0, "rst_avg_torque");
        expect_v(K_CAD,  13'h0, "rst_cadence");
        expect_v(K_NP,   13'h1, "rst_not_pedaling");
        expect_v(K_ERR,  13'h0, "rst_error");
        rst = 1'b0;

        // Window 1: 8 pulses
        pulses(8);
        wait_cyc(4095);
        expect_v(K_CAD, 13'd0, "w1_cad_before_latch");
        expect_v(K_NP,  13'd1, "w1_np_before_latch");
        tick();
        expect_v(K_CAD, 13'd8, "w1_cadence8");
        expect_v(K_NP,  13'd0, "w1_np0");

        // curr latency with target = 0 (scale 0)
        bif.curr = 12'h400; bif.curr_vld = 1'b1;
        tick();
        bif.curr_vld = 1'b0;
        expect_v(K_CURR, 13'h100, "lat_avg_curr_n1");
        expect_v(K_ERR,  13'h0,   "lat_err_n1_old");
        tick();
        expect_v(K_ERR, 13'h1F00, "lat_err_n2");

        // Window 2: steady state, torque step, dead-band
        pulses(8);
        bif.scale = 3'd4;
        strobes(600, 12'h580, 12'h100);
        repeat (5) tick();
        expect_v(K_TORQ, 13'h580, "ss_avg_torque");
        expect_v(K_CURR, 13'h100, "ss_avg_curr");
        expect_v(K_ERR,  13'h100, "ss_error");

        bif.torque = 12'hFFF; bif.torque_vld = 1'b1;
        tick();
        bif.torque_vld = 1'b0;
        m_ta = m_ta - {5'd0, m_ta[16:5]} + 17'hFFF;
        e_new = err_of(m_ta[16:5], 4, 8, 12'h100);
        expect_v(K_TORQ, {1'b0, m_ta[16:5]}, "step_avg_torque_n1");
        expect_v(K_ERR, 13'h100, "step_err_n1");
        tick(); expect_v(K_ERR, 13'h100, "step_err_n2");
        tick(); expect_v(K_ERR, 13'h100, "step_err_n3");
        tick(); expect_v(K_ERR, e_new,   "step_err_n4");

        strobes(600, 12'h300, 12'h100);
        repeat (5) tick();
        expect_v(K_TORQ, 13'h300,  "db_avg_torque");
        expect_v(K_ERR,  13'h1F00, "db_error");
        wait_cyc(8192);
        expect_v(K_CAD, 13'd8, "w2_cadence8");

        // Window 3: 40 pulses saturate; full-scale torque, zero current
        bif.scale = 3'd7;
        pulses(40);
        strobes(600, 12'hFFF, 12'h000);
        wait_cyc(12288);
        expect_v(K_CAD, 13'd31, "w3_cadence_sat");
        expect_v(K_NP,  13'd0,  "w3_np0");
        repeat (5) tick();
        expect_v(K_TORQ, 13'hFFF,  "sat_avg_torque");
        expect_v(K_CURR, 13'h000,  "sat_avg_curr");
        expect_v(K_ERR,  13'h0FFF, "sat_error");

        // Window 4: one early pulse plus an edge on the terminal cycle
        pulses(1);
        wait_cyc(16381);
        bif.cadence_raw = 1'b1;
        tick(); tick(); tick();
        expect_v(K_CAD, 13'd2, "term_edge_cadence");
        expect_v(K_NP,  13'd0, "term_edge_np");
        bif.cadence_raw = 1'b0;
        repeat (4) tick();
        expect_v(K_ERR, 13'h0577, "cad2_error");

        // Window 5: single pulse drops to not pedaling; torque strobes ignored
        pulses(1);
        wait_cyc(20480);
        expect_v(K_CAD, 13'd1, "w5_cadence1");
        expect_v(K_NP,  13'd1, "w5_np1");
        bif.torque = 12'hFFF; bif.torque_vld = 1'b1;
        tick();
        expect_v(K_TORQ, 13'h0, "np_ta_cleared");
        expect_v(K_ERR,  13'h0, "np_error0");
        tick();
        bif.torque_vld = 1'b0;
        expect_v(K_TORQ, 13'h0, "np_torque_ignored");

        // Mid-window asynchronous reset
        pulses(5);
        rst = 1'b1;
        expect_v(K_CAD, 13'd0, "async_rst_cadence");
        expect_v(K_NP,  13'd1, "async_rst_np");
        expect_v(K_ERR, 13'd0, "async_rst_error");
        tick(); tick();
        rst = 1'b0;
        pulses(3);
        wait_cyc(4095);
        expect_v(K_CAD, 13'd0, "post_rst_before_latch");
        tick();
        expect_v(K_CAD, 13'd3, "post_rst_cadence3");
        expect_v(K_NP,  13'd0, "post_rst_np0");

        tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
